// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with 2-entry skid buffer
//
// Purpose:
//   One lc3b pipeline stage register carrying a control word and a data
//   bundle. It uses a valid/ready handshake. The second (skid) entry lets
//   in_ready come straight from a flop, so a downstream stall never forms
//   a combinational path back to the upstream stage. A stage with no stall
//   logic ties out_ready to 1.
//
// Optional feature:
//   PIPE_STAGE_STATS_EN - when defined, stall_count is a 32-bit saturating
//   count of cycles with out_valid=1 and out_ready=0. When undefined,
//   stall_count is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset (wins over flush)
//   flush        in   synchronous kill of both held entries
//   in_valid     in   upstream presents an item
//   in_ready     out  stage can accept (registered)
//   in_ctrl      in   upstream control word  [CTRL_WIDTH]
//   in_data      in   upstream data bundle   [DATA_WIDTH]
//   out_valid    out  head entry valid
//   out_ready    in   downstream accepts head entry
//   out_ctrl     out  head control word, NOP_CTRL while !out_valid
//   out_data     out  head data bundle, keeps its last value while invalid
//   stall_count  out  stall statistic [32]

module pipe_stage_reg #(
  parameter int                    CTRL_WIDTH = 16,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [CTRL_WIDTH-1:0] NOP_CTRL   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           stall_count
);

  // Occupancy state; each entry's valid bit is implied by the state.
  localparam logic [1:0] ST_EMPTY = 2'd0;  // no entry held
  localparam logic [1:0] ST_FULL  = 2'd1;  // main entry only
  localparam logic [1:0] ST_SKID  = 2'd2;  // main and skid entries

  logic [1:0]            r_state;
  logic                  r_in_ready;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic [1:0] w_next_state;
  logic       w_main_valid;
  logic       w_accept;
  logic       w_consume;
  logic       w_load_main_in;
  logic       w_load_main_skid;
  logic       w_load_skid;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_accept     = in_valid & r_in_ready;
  assign w_consume    = w_main_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state   = ST_FULL;
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && w_consume) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          // Downstream stalled: park the new item behind the head entry.
          w_next_state = ST_SKID;
          w_load_skid  = 1'b1;
        end else if (w_consume) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so the only possible event is a consume.
        if (w_consume) begin
          w_next_state     = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= NOP_CTRL;
      r_main_data <= '0;
      r_skid_ctrl <= NOP_CTRL;
      r_skid_data <= '0;
    end else if (flush) begin
      // Entry payloads are left untouched; only occupancy is killed.
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      // Registered ready: decided from the next state, not from out_ready.
      r_in_ready <= (w_next_state != ST_SKID);
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? r_main_ctrl : NOP_CTRL;
  assign out_data  = r_main_data;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_count;

  // Saturating count of stalled head cycles; flush deliberately leaves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard testbench for pipe_stage_reg

module tb_pipe_stage_reg;

  localparam logic [15:0] NOP = 16'h0001;

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [31:0] STALL_EXP = 32'd5;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ctrl;
  logic [63:0] out_data;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [79:0] exp_q[$];

  pipe_stage_reg #(
    .CTRL_WIDTH(16),
    .DATA_WIDTH(64),
    .NOP_CTRL  (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    exp_q.push_back({c, d});
  endtask

  // Monitor: every consume seen between edges is checked against the queue head.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got ctrl %h data %h expected none", out_ctrl, out_data);
      end else begin
        logic [79:0] item;
        item = exp_q.pop_front();
        pops++;
        chk("sb_ctrl", 64'(out_ctrl), 64'(item[79:64]));
        chk("sb_data", out_data, item[63:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 16'h0;
    in_data   = 64'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    reset = 1'b0;

    // Streaming 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      present(16'h0100 + 16'(i), 64'hA000_0000_0000_0000 + 64'(i));
      tick();
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i == 1) begin
        chk("stream_latency_valid", 64'(out_valid), 64'd1);
        chk("stream_latency_data", out_data, 64'hA000_0000_0000_0001);
      end
    end

    // Bubbles.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_valid", 64'(out_valid), 64'd0);
      chk("bubble_ctrl", 64'(out_ctrl), 64'(NOP));
    end

    // Skid fill with A then B.
    out_ready = 1'b0;
    present(16'h0A0A, 64'hAAAA);
    tick();
    chk("skid_a_in_ready", 64'(in_ready), 64'd1);
    chk("skid_a_valid", 64'(out_valid), 64'd1);
    present(16'h0B0B, 64'hBBBB);
    tick();
    chk("skid_full_in_ready", 64'(in_ready), 64'd0);
    chk("skid_hold_data", out_data, 64'hAAAA);
    chk("skid_hold_ctrl", 64'(out_ctrl), 64'h0A0A);
    in_ctrl = 16'hDEAD;
    in_data = 64'hDEAD;
    tick();
    chk("skid_stable_data", out_data, 64'hAAAA);
    chk("skid_stable_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("skid_b_data", out_data, 64'hBBBB);
    chk("skid_b_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("skid_drained", 64'(out_valid), 64'd0);

    // Flush while both entries are held.
    out_ready = 1'b0;
    present(16'h0C01, 64'hC1);
    tick();
    present(16'h0C02, 64'hC2);
    tick();
    chk("flush_pre_in_ready", 64'(in_ready), 64'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 16'h0C03;
    in_data  = 64'hC3;
    exp_q.delete();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_data_kept", out_data, 64'hC1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_c", 64'(out_valid), 64'd0);

    // Reset (with flush) while FULL.
    out_ready = 1'b0;
    present(16'h0D0D, 64'hDDDD);
    tick();
    chk("rmid_full", 64'(out_valid), 64'd1);
    reset    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 16'h0F0F;
    in_data  = 64'hFFFF;
    exp_q.delete();
    tick();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("rmid_valid", 64'(out_valid), 64'd0);
    chk("rmid_data", out_data, 64'd0);
    chk("rmid_in_ready", 64'(in_ready), 64'd1);
    chk("rmid_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("rmid_stall", 64'(stall_count), 64'd0);

    // Stall statistic: five stalled cycles with a valid head.
    present(16'h0E0E, 64'hEEEE);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stats_count", 64'(stall_count), 64'(STALL_EXP));
    out_ready = 1'b1;
    tick();
    chk("stats_hold", 64'(stall_count), 64'(STALL_EXP));
    chk("stats_drained", 64'(out_valid), 64'd0);

    tick();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_pop_count", 64'(pops), 64'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline-stage register for the lc3b pipeline; the generalised successor to the fixed always-load stage registers between IF/ID/EX/MEM/WB.
- Carries one control word and one data bundle per stage.
- Adds a valid/ready handshake, a 2-entry skid buffer so stalls do not create combinational ready paths, and a synchronous flush that inserts bubbles.
- A stage with no stall logic instantiates it with out_ready tied to 1.

Parameters:
CTRL_WIDTH, 16, width of control-word bundle (e.g. $bits of a control-word struct)
DATA_WIDTH, 64, width of concatenated data bundle (pc, alu, mar, mdr, dest, ...)
NOP_CTRL, 0, control value driven on out_ctrl whenever out_valid=0 (bubble)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all held entries (branch/mispredict)
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_ctrl  input  CTRL_WIDTH  upstream control word
in_data  input  DATA_WIDTH  upstream data bundle
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_WIDTH  control word of head entry, NOP_CTRL when !out_valid
out_data  output  DATA_WIDTH  data of head entry
stall_count  output  32  stall statistic (see Optional Feature)

Behaviour:
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry; each has ctrl, data, valid bit.
- States:
  - EMPTY: main and skid invalid.
  - FULL: main valid only.
  - SKID: both valid.
- in_ready = (state != SKID), driven from a register.
- Latency: accepted item appears on out_* the cycle after acceptance (1 cycle); throughput 1/cycle when out_ready=1.
- Transitions:
  - EMPTY: accept -> FULL, main<=in; else stay.
  - FULL, accept & consume -> FULL, main<=in.
  - FULL, accept & !consume -> SKID, skid<=in, main held.
  - FULL, !accept & consume -> EMPTY.
  - FULL, neither -> hold.
  - SKID: consume -> FULL, main<=skid, skid invalid; else hold (no accept possible).
- Ordering: strictly FIFO; skid entry never overtakes main.
- Outputs are stable while out_valid & !out_ready (ctrl and data unchanged).
- out_ctrl = NOP_CTRL when out_valid=0. out_data retains its last value when invalid; it is 0 only after reset.
- Flush:
  - Next state EMPTY; both valid bits cleared; in_ready=1 next cycle.
  - An accept or consume in the flush cycle is discarded. Upstream treats flush as a kill of its own output.
  - Data registers are not cleared by flush.
- Priority: reset > flush > normal handshake.
- Reset: state EMPTY, out_valid=0, in_ready=1, out_ctrl=NOP_CTRL, out_data=0, skid data=0.
  - Reset mid-SKID drops both entries.
  - Reset and flush together behave as reset.
- in_valid/in_ctrl/in_data may change freely while in_ready=0 (not sampled).

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: 32-bit saturating counter stall_count increments every cycle with out_valid=1 & out_ready=0. Holds at 32'hFFFF_FFFF. Cleared by reset only; flush does not clear it. Counter register is readable the cycle after the event.
- Undefined: no counter logic; stall_count tied to 32'h0.

Test Plan:
- Streaming: reset, then in_valid=1 with data 1..8 on consecutive cycles, out_ready=1 -> out_valid from cycle 2, out_data 1..8 in order one per cycle, in_ready stays 1.
- Skid fill: out_ready=0, present A then B -> cycle after B accepted in_ready=0, out_data=A held; raise out_ready -> A, then B, each for 1 cycle, in_ready returns 1 the cycle after A consumed.
- Flush in SKID: hold A,B with out_ready=0, assert flush with C valid -> next cycle out_valid=0, out_ctrl=NOP_CTRL, in_ready=1, C never appears on output.
- Reset mid-operation: FULL with D, assert reset with in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1; D lost.
- Bubble: in_valid=0 for 3 cycles while out_ready=1 -> out_valid=0, out_ctrl=NOP_CTRL (e.g. NOP_CTRL=16'h0001) each cycle.
- Stats (PIPE_STAGE_STATS_EN): out_valid=1, out_ready=0 for 5 cycles -> stall_count=5; without macro -> stall_count=0.
